fp32_multiplier: RTL and testbench

FP32_MULTIPLIER -- requirements
Module: fp32_multiplier

---
 rtl/fp32_multiplier.sv | 224 ++++++++++++++++++++++
 tb/tb_fp32_multiplier.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: IEEE-754 binary32 multiply, round-to-nearest-even, 3-cycle latency, 1/cycle, no backpressure.
// Define FP32_MUL_SUBNORMAL_EN for subnormal results; otherwise tiny results flush to signed zero.
module fp32_multiplier (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_i,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) found = 1'b1;
      else if (!found) n = n + 5'd1;
    end
    return n;
  endfunction

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign a_zero = (A[30:0] == 31'd0);
  assign b_zero = (B[30:0] == 31'd0);
  assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
  assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
  assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
  assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
  assign a_snan = a_nan && !A[22];
  assign b_snan = b_nan && !B[22];

  logic               sign_c, spec_c, spec_inv_c;
  logic [31:0]        spec_res_c;
  logic [23:0]        ma_raw, mb_raw;
  logic [4:0]         lz_a, lz_b;
  logic signed [10:0] ea_n, eb_n;

  // Subnormal operands are normalised here so the product always has its MSB in bit 47 or 46.
  always_comb begin
    sign_c = A[31] ^ B[31];
    ma_raw = {A[30:23] != 8'd0, A[22:0]};
    mb_raw = {B[30:23] != 8'd0, B[22:0]};
    lz_a   = lzc24(ma_raw);
    lz_b   = lzc24(mb_raw);
    ea_n   = $signed((A[30:23] == 8'd0) ? 11'd1 : {3'd0, A[30:23]}) - $signed({6'd0, lz_a});
    eb_n   = $signed((B[30:23] == 8'd0) ? 11'd1 : {3'd0, B[30:23]}) - $signed({6'd0, lz_b});

    spec_c     = 1'b1;
    spec_inv_c = 1'b0;
    spec_res_c = QNAN;
    if (a_nan || b_nan)                               spec_inv_c = a_snan || b_snan;
    else if ((a_zero && b_inf) || (a_inf && b_zero))  spec_inv_c = 1'b1;
    else if (a_inf || b_inf)                          spec_res_c = {sign_c, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                        spec_res_c = {sign_c, 31'd0};
    else                                              spec_c     = 1'b0;
  end

  logic s1_vld, s2_vld, s3_vld;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      s1_vld <= valid_i;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  logic               s1_sign, s1_spec, s1_spec_inv;
  logic [31:0]        s1_spec_res;
  logic [23:0]        s1_ma, s1_mb;
  logic signed [10:0] s1_exp;

  always_ff @(posedge clk) begin
    if (valid_i) begin
      s1_sign     <= sign_c;
      s1_spec     <= spec_c;
      s1_spec_inv <= spec_inv_c;
      s1_spec_res <= spec_res_c;
      s1_ma       <= ma_raw << lz_a;
      s1_mb       <= mb_raw << lz_b;
      s1_exp      <= ea_n + eb_n - 11'sd127;
    end
  end

  logic               s2_sign, s2_spec, s2_spec_inv;
  logic [31:0]        s2_spec_res;
  logic [47:0]        s2_prod;
  logic signed [10:0] s2_exp;

  always_ff @(posedge clk) begin
    if (s1_vld) begin
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_res <= s1_spec_res;
      s2_exp      <= s1_exp;
      s2_prod     <= {24'd0, s1_ma} * {24'd0, s1_mb};
    end
  end

  logic [46:0]        n_m;
  logic signed [10:0] n_e;
  logic               tiny_c, ovf_c, g_c, r_c, s_c;
  logic [7:0]         exp_c;
  logic [22:0]        man_c;
`ifdef FP32_MUL_SUBNORMAL_EN
  logic signed [10:0] sh_full;
  logic [5:0]         sub_sh;
  logic [46:0]        sub_m;
  logic               sub_lost;
`endif

  // n_m holds the fraction below the implied one; n_e is the biased exponent before rounding.
  always_comb begin
    n_m    = s2_prod[47] ? s2_prod[46:0] : {s2_prod[45:0], 1'b0};
    n_e    = s2_prod[47] ? s2_exp + 11'sd1 : s2_exp;
    tiny_c = (n_e < 11'sd1);
    ovf_c  = (n_e > 11'sd254);
    exp_c  = n_e[7:0];
    man_c  = n_m[46:24];
    g_c    = n_m[23];
    r_c    = n_m[22];
    s_c    = |n_m[21:0];
`ifdef FP32_MUL_SUBNORMAL_EN
    sh_full  = 11'sd1 - n_e;
    sub_sh   = (sh_full > 11'sd48) ? 6'd48 : sh_full[5:0];
    sub_m    = 47'({1'b1, n_m} >> sub_sh);
    sub_lost = |({1'b1, n_m} & ~({48{1'b1}} << sub_sh));
    if (tiny_c) begin
      exp_c = 8'd0;
      man_c = sub_m[46:24];
      g_c   = sub_m[23];
      r_c   = sub_m[22];
      s_c   = (|sub_m[21:0]) | sub_lost;
    end
`endif
  end

  logic               s3_sign, s3_spec, s3_spec_inv, s3_tiny, s3_ovf, s3_g, s3_r, s3_s;
  logic [31:0]        s3_spec_res;
  logic [7:0]         s3_exp;
  logic [22:0]        s3_man;

  always_ff @(posedge clk) begin
    if (s2_vld) begin
      s3_sign     <= s2_sign;
      s3_spec     <= s2_spec;
      s3_spec_inv <= s2_spec_inv;
      s3_spec_res <= s2_spec_res;
      s3_tiny     <= tiny_c;
      s3_ovf      <= ovf_c;
      s3_exp      <= exp_c;
      s3_man      <= man_c;
      s3_g        <= g_c;
      s3_r        <= r_c;
      s3_s        <= s_c;
    end
  end

  logic        inc_c, ovf_o_c, unf_o_c, inv_o_c;
  logic [30:0] rnd_c;
  logic [31:0] res_c;

  // Rounding across {exp, man} lets a mantissa carry bump the exponent, including subnormal -> normal.
  always_comb begin
    inc_c   = s3_g & (s3_r | s3_s | s3_man[0]);
    rnd_c   = {s3_exp, s3_man} + {30'd0, inc_c};
    res_c   = {s3_sign, rnd_c};
    ovf_o_c = 1'b0;
    unf_o_c = 1'b0;
    inv_o_c = 1'b0;
    if (s3_spec) begin
      res_c   = s3_spec_res;
      inv_o_c = s3_spec_inv;
    end
`ifndef FP32_MUL_SUBNORMAL_EN
    else if (s3_tiny) begin
      res_c   = {s3_sign, 31'd0};
      unf_o_c = 1'b1;
    end
`endif
    else if (s3_ovf || rnd_c[30:23] == 8'hFF) begin
      res_c   = {s3_sign, 8'hFF, 23'd0};
      ovf_o_c = 1'b1;
    end
`ifdef FP32_MUL_SUBNORMAL_EN
    else begin
      unf_o_c = s3_tiny & (s3_g | s3_r | s3_s);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      done_o      <= 1'b0;
      result_o    <= 32'd0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      done_o <= s3_vld;
      if (s3_vld) begin
        result_o    <= res_c;
        overflow_o  <= ovf_o_c;
        underflow_o <= unf_o_c;
        invalid_o   <= inv_o_c;
      end
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Bench for fp32_multiplier: directed table, reset flush, bubbly and back-to-back random streams.
// Honours FP32_MUL_SUBNORMAL_EN the same way as the design.
module tb_fp32_multiplier;

  logic        clk;
  logic        rstn;
  logic        valid_i;
  logic [31:0] A, B;
  logic [31:0] result_o;
  logic        done_o, overflow_o, underflow_o, invalid_o;

  fp32_multiplier dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .A(A), .B(B),
    .result_o(result_o), .done_o(done_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o), .invalid_o(invalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inv;
  } out_t;

  typedef struct {
    int unsigned issue;
    out_t        o;
  } pend_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    out_t        o;
  } vec_t;

  pend_t       pend_q[$];
  vec_t        tbl[$];
  out_t        held;
  int unsigned cyc, n_chk, n_pass, run, max_run;
  string       tag;

  // Value-level reference: operand = sig * 2^x, product rounded to the binary32 grid.
  function automatic out_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    out_t              o;
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, tiny, inexact;
    longint unsigned   sa, sb, p, sig, rem, half;
    int                xa, xb, x, k, ue, q, sh;
    o      = '0;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    if (a_nan || b_nan) begin
      o.res = 32'h7FC0_0000;
      o.inv = (a_nan && !a[22]) || (b_nan && !b[22]);
      return o;
    end
    if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      o.res = 32'h7FC0_0000;
      o.inv = 1'b1;
      return o;
    end
    if (a_inf || b_inf) begin o.res = {sgn, 8'hFF, 23'h0}; return o; end
    if (a_zero || b_zero) begin o.res = {sgn, 31'h0}; return o; end
    sa = (a[30:23] == 0) ? {41'b0, a[22:0]} : {40'b0, 1'b1, a[22:0]};
    sb = (b[30:23] == 0) ? {41'b0, b[22:0]} : {40'b0, 1'b1, b[22:0]};
    xa = (a[30:23] == 0) ? -149 : int'(a[30:23]) - 150;
    xb = (b[30:23] == 0) ? -149 : int'(b[30:23]) - 150;
    p  = sa * sb;
    x  = xa + xb;
    k  = 0;
    for (int i = 0; i < 48; i++) if (p[i]) k = i;
    ue   = k + x;
    tiny = (ue < -126);
`ifdef FP32_MUL_SUBNORMAL_EN
    q = (tiny ? -126 : ue) - 23;
`else
    if (tiny) begin
      o.res = {sgn, 31'h0};
      o.unf = 1'b1;
      return o;
    end
    q = ue - 23;
`endif
    sh = q - x;
    if (sh <= 0) begin
      sig = p << (-sh);
      inexact = 1'b0;
    end else if (sh >= 60) begin
      sig = 0;
      inexact = 1'b1;
    end else begin
      sig  = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && sig[0])) sig++;
    end
    if (sig >= (64'd1 << 24)) begin sig >>= 1; q++; end
    if (sig >= (64'd1 << 23)) begin
      if (q + 150 >= 255) begin
        o.res = {sgn, 8'hFF, 23'h0};
        o.ovf = 1'b1;
        return o;
      end
      o.res = {sgn, 8'(q + 150), sig[22:0]};
    end else begin
      o.res = {sgn, 8'h00, sig[22:0]};
    end
`ifdef FP32_MUL_SUBNORMAL_EN
    o.unf = tiny && inexact;
`endif
    return o;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [31:0] sp [0:6];
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0000, 32'h7F80_0001, 32'hFFA0_0000};
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = sp[$urandom_range(0, 6)];
      1: r[30:23] = 8'h00;
      2: r[30:23] = 8'($urandom_range(1, 40));
      3: r[30:23] = 8'($urandom_range(200, 254));
      4: r[30:23] = 8'($urandom_range(90, 160));
      default: ;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [2:0] fl);
    vec_t v;
    v.a = a;
    v.b = b;
    v.o = {res, fl};
    return v;
  endfunction

  // One clock; afterwards the full output tuple is compared to the expected done/result/flags.
  task automatic tick();
    out_t e;
    logic e_done;
    @(posedge clk);
    cyc++;
    #1;
    e_done = 1'b0;
    e      = held;
    if (pend_q.size() > 0 && pend_q[0].issue + 3 == cyc) begin
      e_done = 1'b1;
      e      = pend_q[0].o;
      held   = e;
      void'(pend_q.pop_front());
    end
    n_chk++;
    if ({done_o, result_o, overflow_o, underflow_o, invalid_o} === {e_done, e}) n_pass++;
    else $display("FAIL %s cyc=%0d: got done=%b res=%h ovf/unf/inv=%b%b%b, required done=%b res=%h ovf/unf/inv=%b%b%b",
                  tag, cyc, done_o, result_o, overflow_o, underflow_o, invalid_o,
                  e_done, e.res, e.ovf, e.unf, e.inv);
    if (done_o === 1'b1) run++;
    else run = 0;
    if (run > max_run) max_run = run;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input out_t e);
    pend_t p;
    A       = a;
    B       = b;
    valid_i = 1'b1;
    p.issue = cyc + 1;
    p.o     = e;
    pend_q.push_back(p);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      A = $urandom;
      B = $urandom;
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    rstn    = 1'b0;
    valid_i = 1'b0;
    pend_q.delete();
    held = '0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1'b1;
  endtask

  task automatic check(input string name, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, want);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0; run = 0; max_run = 0;
    rstn = 1'b0; valid_i = 1'b0; A = '0; B = '0; held = '0;

    // flags column is {overflow, underflow, invalid}
    tbl.push_back(mk(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 3'b000));
    tbl.push_back(mk(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000));
    tbl.push_back(mk(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b100));
    tbl.push_back(mk(32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001));
    tbl.push_back(mk(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001));
    tbl.push_back(mk(32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 3'b000));
    tbl.push_back(mk(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000));
    tbl.push_back(mk(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000));
    tbl.push_back(mk(32'h7F7F_FFFF, 32'h3F80_0001, 32'h7F80_0000, 3'b100));
    tbl.push_back(mk(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000));
    tbl.push_back(mk(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3'b000));
    tbl.push_back(mk(32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b000));
    tbl.push_back(mk(32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 3'b001));
    tbl.push_back(mk(32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000, 3'b001));
    tbl.push_back(mk(32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b000));
    tbl.push_back(mk(32'h0000_0001, 32'h4B00_0000, 32'h0080_0000, 3'b000));
    tbl.push_back(mk(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 3'b000));
    tbl.push_back(mk(32'h8000_0001, 32'h3F00_0000, 32'h8000_0000, 3'b010));
`ifdef FP32_MUL_SUBNORMAL_EN
    tbl.push_back(mk(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 3'b000));
    tbl.push_back(mk(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 3'b000));
    tbl.push_back(mk(32'h007F_FFFF, 32'h3F80_0001, 32'h0080_0000, 3'b010));
    tbl.push_back(mk(32'h0000_0003, 32'h3F00_0000, 32'h0000_0002, 3'b010));
`else
    tbl.push_back(mk(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010));
    tbl.push_back(mk(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b010));
    tbl.push_back(mk(32'h007F_FFFF, 32'h3F80_0001, 32'h0000_0000, 3'b010));
    tbl.push_back(mk(32'h0000_0003, 32'h3F00_0000, 32'h0000_0000, 3'b010));
`endif

    tag = "reset";
    do_reset(2);

    tag = "single_pulse";
    issue(tbl[0].a, tbl[0].b, tbl[0].o);
    idle(5);

    tag = "table";
    for (int i = 1; i < tbl.size(); i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].o);
      if (i % 3 == 2) idle(1);
    end
    idle(5);

    tag = "reset_flush";
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = rand_op();
      issue(a, b, ref_mul(a, b));
    end
    do_reset(1);
    idle(4);
    issue(32'h3F80_0000, 32'h4040_0000, {32'h4040_0000, 3'b000});
    idle(5);

    tag = "random_bubbles";
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = rand_op();
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(a, b, ref_mul(a, b));
    end
    idle(5);

    tag = "random_stream";
    run = 0;
    max_run = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = rand_op();
      issue(a, b, ref_mul(a, b));
    end
    idle(6);
    check("done_run_length", max_run, 10000);
    check("pending_after_drain", pend_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
